// File: rtl/alarm_ring_scheduler_if.sv
// Alarm ring scheduler bus: tick/request/ack/snooze inputs and buzzer/status outputs.
// Slave is the scheduler; master is whatever drives it (main_unit side / testbench).
interface alarm_ring_scheduler_if;
   logic       tick;
   logic [2:0] ring_req;
   logic       ack;
   logic       snooze;
   logic       buzzer;
   logic [1:0] active_id;
   logic [2:0] pending;
   logic [2:0] snoozed;

   modport master (
      output tick, ring_req, ack, snooze,
      input  buzzer, active_id, pending, snoozed
   );

   modport slave (
      input  tick, ring_req, ack, snooze,
      output buzzer, active_id, pending, snoozed
   );
endinterface

// File: rtl/alarm_ring_scheduler.sv
// Latches rising edges of three alarm levels and rings them one at a time on a buzzer.
// Define ALARM_SNOOZE_EN to build per-alarm snooze timers; otherwise snooze acts as ack.
module alarm_ring_scheduler #(
   parameter int RING_SECS   = 60,
   parameter int SNOOZE_SECS = 300
) (
   input logic                   clk,
   input logic                   rst,
   alarm_ring_scheduler_if.slave bus
);
   localparam int RING_W = $clog2(RING_SECS + 1);

   typedef enum logic {S_IDLE, S_RING} state_t;

   state_t            r_state;
   logic              r_buzzer;
   logic [1:0]        r_active_id;
   logic [RING_W-1:0] r_ring_cnt;
   logic [2:0]        r_req_d;

   logic [2:0] w_rise;
   logic [2:0] w_pending;
   logic [2:0] w_snoozed;
   logic [2:0] w_ring_mask;
   logic [2:0] w_win_mask;
   logic [2:0] w_snz_expire;
   logic [1:0] w_win_idx;
   logic       w_start;
   logic       w_timeout;
   logic       w_ring_end;

   assign w_rise     = bus.ring_req & ~r_req_d;
   assign w_start    = (r_state == S_IDLE) && (w_pending != 3'b000);
   assign w_timeout  = bus.tick && (r_ring_cnt == RING_W'(RING_SECS - 1));
   assign w_ring_end = bus.ack | bus.snooze | w_timeout;

   // Alarm one has the highest priority.
   always_comb begin
      w_win_idx = 2'd0;
      if (w_pending[0])
         w_win_idx = 2'd0;
      else if (w_pending[1])
         w_win_idx = 2'd1;
      else if (w_pending[2])
         w_win_idx = 2'd2;
   end

   // Reset to all-ones so levels already high at reset release are not seen as edges.
   always_ff @(posedge clk) begin
      if (rst)
         r_req_d <= 3'b111;
      else
         r_req_d <= bus.ring_req;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_buzzer    <= 1'b0;
         r_active_id <= 2'd0;
         r_ring_cnt  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_start) begin
                  r_state     <= S_RING;
                  r_buzzer    <= 1'b1;
                  r_active_id <= w_win_idx + 2'd1;
                  r_ring_cnt  <= '0;
               end
            end
            S_RING: begin
               if (w_ring_end) begin
                  r_state     <= S_IDLE;
                  r_buzzer    <= 1'b0;
                  r_active_id <= 2'd0;
               end else if (bus.tick) begin
                  r_ring_cnt <= r_ring_cnt + RING_W'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 3; gi++) begin : g_chan
         logic r_pend;

         assign w_win_mask[gi]  = (w_win_idx == 2'(gi));
         assign w_ring_mask[gi] = (r_state == S_RING) && (r_active_id == 2'(gi + 1));
         assign w_pending[gi]   = r_pend;

         // A new edge on the channel currently ringing is dropped.
         always_ff @(posedge clk) begin
            if (rst)
               r_pend <= 1'b0;
            else
               r_pend <= (r_pend & ~(w_start & w_win_mask[gi]))
                       | (w_rise[gi] & ~w_ring_mask[gi])
                       | w_snz_expire[gi];
         end

`ifdef ALARM_SNOOZE_EN
         localparam int SNZ_W = $clog2(SNOOZE_SECS + 1);

         logic             r_snz;
         logic [SNZ_W-1:0] r_snz_cnt;
         logic             w_snz_start;

         assign w_snz_start      = w_ring_mask[gi] & bus.snooze & ~bus.ack;
         assign w_snz_expire[gi] = r_snz & bus.tick & (r_snz_cnt == SNZ_W'(1));
         assign w_snoozed[gi]    = r_snz;

         // A fresh edge cancels the snooze; the pending bit is set by the edge itself.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_snz     <= 1'b0;
               r_snz_cnt <= '0;
            end else if (r_snz && w_rise[gi]) begin
               r_snz <= 1'b0;
            end else if (w_snz_start) begin
               r_snz     <= 1'b1;
               r_snz_cnt <= SNZ_W'(SNOOZE_SECS);
            end else if (r_snz && bus.tick) begin
               r_snz_cnt <= r_snz_cnt - SNZ_W'(1);
               if (r_snz_cnt == SNZ_W'(1))
                  r_snz <= 1'b0;
            end
         end
`else
         assign w_snz_expire[gi] = 1'b0;
         assign w_snoozed[gi]    = 1'b0;
`endif
      end
   endgenerate

   assign bus.buzzer    = r_buzzer;
   assign bus.active_id = r_active_id;
   assign bus.pending   = w_pending;
   assign bus.snoozed   = w_snoozed;
endmodule

// File: tb/tb_alarm_ring_scheduler.sv
// Directed bench for alarm_ring_scheduler (RING_SECS=4, SNOOZE_SECS=6).
// Status word checked as {buzzer, active_id[1:0], pending[2:0], snoozed[2:0]}.
module tb_alarm_ring_scheduler;
   logic       clk = 1'b0;
   logic       rst;
   int         checks = 0;
   int         errors = 0;
   int         tick_ctr = 0;
   bit         slow_tick = 1'b0;
   logic [8:0] obs;
   logic [8:0] exp_v;
   logic [2:0] exp_snz;

   alarm_ring_scheduler_if bus ();

   alarm_ring_scheduler #(
      .RING_SECS   (4),
      .SNOOZE_SECS (6)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   function automatic logic [8:0] snap();
      return {bus.buzzer, bus.active_id, bus.pending, bus.snoozed};
   endfunction

   // Advance one edge, sample just after it, and set up tick for the next edge.
   task automatic step();
      @(posedge clk);
      #1;
      tick_ctr++;
      if (slow_tick)
         bus.tick = (tick_ctr % 3 == 1);
      else
         bus.tick = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      step();
      step();
      checks++; obs = snap(); exp_v = 9'b0_00_000_000;
      if (obs !== exp_v) begin errors++; $display("FAIL reset_state got=%b exp=%b", obs, exp_v); end
      rst = 1'b0;
      step();
      step();
      $display("test_reset done checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_single();
      bus.ring_req = 3'b001;
      step();
      checks++; obs = snap(); exp_v = 9'b0_00_001_000;
      if (obs !== exp_v) begin errors++; $display("FAIL single_pend got=%b exp=%b", obs, exp_v); end
      step();
      checks++; obs = snap(); exp_v = 9'b1_01_000_000;
      if (obs !== exp_v) begin errors++; $display("FAIL single_ring got=%b exp=%b", obs, exp_v); end
      repeat (3) step();
      checks++; obs = snap(); exp_v = 9'b1_01_000_000;
      if (obs !== exp_v) begin errors++; $display("FAIL single_last got=%b exp=%b", obs, exp_v); end
      step();
      checks++; obs = snap(); exp_v = 9'b0_00_000_000;
      if (obs !== exp_v) begin errors++; $display("FAIL single_timeout got=%b exp=%b", obs, exp_v); end
      bus.ring_req = 3'b000;
      step();
      step();
      $display("test_single done checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_priority();
      bus.ring_req = 3'b111;
      step();
      checks++; obs = snap(); exp_v = 9'b0_00_111_000;
      if (obs !== exp_v) begin errors++; $display("FAIL prio_pend got=%b exp=%b", obs, exp_v); end
      step();
      checks++; obs = snap(); exp_v = 9'b1_01_110_000;
      if (obs !== exp_v) begin errors++; $display("FAIL prio_ring1 got=%b exp=%b", obs, exp_v); end
      repeat (3) step();
      step();
      checks++; obs = snap(); exp_v = 9'b0_00_110_000;
      if (obs !== exp_v) begin errors++; $display("FAIL prio_idle1 got=%b exp=%b", obs, exp_v); end
      step();
      checks++; obs = snap(); exp_v = 9'b1_10_100_000;
      if (obs !== exp_v) begin errors++; $display("FAIL prio_ring2 got=%b exp=%b", obs, exp_v); end
      repeat (3) step();
      step();
      checks++; obs = snap(); exp_v = 9'b0_00_100_000;
      if (obs !== exp_v) begin errors++; $display("FAIL prio_idle2 got=%b exp=%b", obs, exp_v); end
      step();
      checks++; obs = snap(); exp_v = 9'b1_11_000_000;
      if (obs !== exp_v) begin errors++; $display("FAIL prio_ring3 got=%b exp=%b", obs, exp_v); end
      repeat (3) step();
      step();
      checks++; obs = snap(); exp_v = 9'b0_00_000_000;
      if (obs !== exp_v) begin errors++; $display("FAIL prio_done got=%b exp=%b", obs, exp_v); end
      bus.ring_req = 3'b000;
      step();
      step();
      $display("test_priority done checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_ack();
      bus.ring_req = 3'b010;
      step();
      step();
      checks++; obs = snap(); exp_v = 9'b1_10_000_000;
      if (obs !== exp_v) begin errors++; $display("FAIL ack_ring got=%b exp=%b", obs, exp_v); end
      bus.ack = 1'b1;
      step();
      bus.ack = 1'b0;
      checks++; obs = snap(); exp_v = 9'b0_00_000_000;
      if (obs !== exp_v) begin errors++; $display("FAIL ack_stop got=%b exp=%b", obs, exp_v); end
      bus.ring_req = 3'b000;
      step();
      step();
      bus.ring_req = 3'b010;
      step();
      step();
      bus.ack    = 1'b1;
      bus.snooze = 1'b1;
      step();
      bus.ack    = 1'b0;
      bus.snooze = 1'b0;
      checks++; obs = snap(); exp_v = 9'b0_00_000_000;
      if (obs !== exp_v) begin errors++; $display("FAIL ack_snooze_both got=%b exp=%b", obs, exp_v); end
      repeat (8) step();
      checks++; obs = snap(); exp_v = 9'b0_00_000_000;
      if (obs !== exp_v) begin errors++; $display("FAIL ack_no_rering got=%b exp=%b", obs, exp_v); end
      bus.ring_req = 3'b000;
      step();
      step();
      $display("test_ack done checks=%0d errors=%0d", checks, errors);
   endtask

`ifdef ALARM_SNOOZE_EN
   task automatic test_snooze();
      bus.ring_req = 3'b100;
      step();
      step();
      checks++; obs = snap(); exp_v = 9'b1_11_000_000;
      if (obs !== exp_v) begin errors++; $display("FAIL snz_ring got=%b exp=%b", obs, exp_v); end
      bus.snooze = 1'b1;
      step();
      bus.snooze = 1'b0;
      checks++; obs = snap(); exp_v = 9'b0_00_000_100;
      if (obs !== exp_v) begin errors++; $display("FAIL snz_start got=%b exp=%b", obs, exp_v); end
      repeat (5) step();
      checks++; obs = snap(); exp_v = 9'b0_00_000_100;
      if (obs !== exp_v) begin errors++; $display("FAIL snz_wait got=%b exp=%b", obs, exp_v); end
      step();
      checks++; obs = snap(); exp_v = 9'b0_00_100_000;
      if (obs !== exp_v) begin errors++; $display("FAIL snz_expire got=%b exp=%b", obs, exp_v); end
      step();
      checks++; obs = snap(); exp_v = 9'b1_11_000_000;
      if (obs !== exp_v) begin errors++; $display("FAIL snz_rering got=%b exp=%b", obs, exp_v); end
      bus.snooze = 1'b1;
      step();
      bus.snooze = 1'b0;
      checks++; obs = snap(); exp_v = 9'b0_00_000_100;
      if (obs !== exp_v) begin errors++; $display("FAIL snz_again got=%b exp=%b", obs, exp_v); end
      bus.ring_req = 3'b000;
      step();
      bus.ring_req = 3'b100;
      step();
      checks++; obs = snap(); exp_v = 9'b0_00_100_000;
      if (obs !== exp_v) begin errors++; $display("FAIL snz_cancel got=%b exp=%b", obs, exp_v); end
      step();
      checks++; obs = snap(); exp_v = 9'b1_11_000_000;
      if (obs !== exp_v) begin errors++; $display("FAIL snz_cancel_ring got=%b exp=%b", obs, exp_v); end
      bus.ack = 1'b1;
      step();
      bus.ack = 1'b0;
      bus.ring_req = 3'b000;
      step();
      step();
      $display("test_snooze done checks=%0d errors=%0d", checks, errors);
   endtask
`else
   task automatic test_snooze();
      bus.ring_req = 3'b100;
      step();
      step();
      checks++; obs = snap(); exp_v = 9'b1_11_000_000;
      if (obs !== exp_v) begin errors++; $display("FAIL snz_ring got=%b exp=%b", obs, exp_v); end
      bus.snooze = 1'b1;
      step();
      bus.snooze = 1'b0;
      checks++; obs = snap(); exp_v = 9'b0_00_000_000;
      if (obs !== exp_v) begin errors++; $display("FAIL snz_as_ack got=%b exp=%b", obs, exp_v); end
      repeat (8) step();
      checks++; obs = snap(); exp_v = 9'b0_00_000_000;
      if (obs !== exp_v) begin errors++; $display("FAIL snz_no_rering got=%b exp=%b", obs, exp_v); end
      bus.ring_req = 3'b000;
      step();
      step();
      $display("test_snooze done checks=%0d errors=%0d", checks, errors);
   endtask
`endif

   task automatic test_reset_mid();
`ifdef ALARM_SNOOZE_EN
      exp_snz = 3'b100;
`else
      exp_snz = 3'b000;
`endif
      bus.ring_req = 3'b100;
      step();
      step();
      bus.snooze = 1'b1;
      step();
      bus.snooze = 1'b0;
      checks++; obs = snap(); exp_v = {1'b0, 2'b00, 3'b000, exp_snz};
      if (obs !== exp_v) begin errors++; $display("FAIL rstmid_snooze got=%b exp=%b", obs, exp_v); end
      bus.ring_req = 3'b101;
      step();
      checks++; obs = snap(); exp_v = {1'b0, 2'b00, 3'b001, exp_snz};
      if (obs !== exp_v) begin errors++; $display("FAIL rstmid_pend got=%b exp=%b", obs, exp_v); end
      step();
      checks++; obs = snap(); exp_v = {1'b1, 2'b01, 3'b000, exp_snz};
      if (obs !== exp_v) begin errors++; $display("FAIL rstmid_ring got=%b exp=%b", obs, exp_v); end
      rst = 1'b1;
      step();
      checks++; obs = snap(); exp_v = 9'b0_00_000_000;
      if (obs !== exp_v) begin errors++; $display("FAIL rstmid_clear got=%b exp=%b", obs, exp_v); end
      step();
      rst = 1'b0;
      repeat (10) step();
      checks++; obs = snap(); exp_v = 9'b0_00_000_000;
      if (obs !== exp_v) begin errors++; $display("FAIL rstmid_held_level got=%b exp=%b", obs, exp_v); end
      bus.ring_req = 3'b000;
      step();
      step();
      $display("test_reset_mid done checks=%0d errors=%0d", checks, errors);
   endtask

   task automatic test_slow_tick();
      int ring_len;
      slow_tick = 1'b1;
      tick_ctr  = 0;
      bus.tick  = 1'b0;
      bus.ring_req = 3'b001;
      step();
      checks++; obs = snap(); exp_v = 9'b0_00_001_000;
      if (obs !== exp_v) begin errors++; $display("FAIL slow_pend got=%b exp=%b", obs, exp_v); end
      step();
      checks++; obs = snap(); exp_v = 9'b1_01_000_000;
      if (obs !== exp_v) begin errors++; $display("FAIL slow_ring got=%b exp=%b", obs, exp_v); end
      ring_len = 1;
      for (int i = 0; i < 40 && bus.buzzer === 1'b1; i++) begin
         step();
         if (bus.buzzer === 1'b1)
            ring_len++;
      end
      checks++;
      if (ring_len != 12) begin errors++; $display("FAIL slow_ring_len got=%0d exp=12", ring_len); end
      checks++; obs = snap(); exp_v = 9'b0_00_000_000;
      if (obs !== exp_v) begin errors++; $display("FAIL slow_end got=%b exp=%b", obs, exp_v); end
      bus.ack = 1'b1;
      step();
      bus.ack = 1'b0;
      step();
      checks++; obs = snap(); exp_v = 9'b0_00_000_000;
      if (obs !== exp_v) begin errors++; $display("FAIL idle_ack got=%b exp=%b", obs, exp_v); end
      bus.snooze = 1'b1;
      step();
      bus.snooze = 1'b0;
      repeat (8) step();
      checks++; obs = snap(); exp_v = 9'b0_00_000_000;
      if (obs !== exp_v) begin errors++; $display("FAIL idle_snooze got=%b exp=%b", obs, exp_v); end
      bus.ring_req = 3'b000;
      slow_tick = 1'b0;
      step();
      step();
      $display("test_slow_tick done checks=%0d errors=%0d", checks, errors);
   endtask

   initial begin
      rst          = 1'b1;
      bus.tick     = 1'b1;
      bus.ring_req = 3'b000;
      bus.ack      = 1'b0;
      bus.snooze   = 1'b0;
      test_reset();
      test_single();
      test_priority();
      test_ack();
      test_snooze();
      test_reset_mid();
      test_slow_tick();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end
endmodule
